// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: next-PC candidates and control from the core, PC and fetch status back.
// The slave modport is the fetch unit's view; the master modport is the core/memory side.
interface fetch_if;
    localparam int unsigned AW = 16;

    logic [AW-1:0] pcin;
    logic [AW-1:0] pcbranch;
    logic [AW-1:0] pcjump;
    logic [1:0]    pcsel;
    logic          pc_en;
    logic          halt;
    logic          resume;
    logic          mem_ready;

    logic [AW-1:0] pcout;
    logic          mem_req;
    logic          ins_valid;
    logic          halted;
    logic          fault;
    logic [AW-1:0] ins_count;

    modport master (
        output pcin, pcbranch, pcjump, pcsel, pc_en, halt, resume, mem_ready,
        input  pcout, mem_req, ins_valid, halted, fault, ins_count
    );

    modport slave (
        input  pcin, pcbranch, pcjump, pcsel, pc_en, halt, resume, mem_ready,
        output pcout, mem_req, ins_valid, halted, fault, ins_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Program-counter and instruction-fetch sequencer: holds the PC, handshakes with
// instruction memory, retires instructions on pc_en and handles halt/resume/timeout.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  WAIT_MAX = 4'd15
) (
    input  logic   clock,
    input  logic   reset_n,
    fetch_if.slave bus
);
    localparam int unsigned AW = 16;
    localparam int unsigned WW = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        HALT  = 3'd3,
        FAULT = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic          mem_req_q;
    logic          ins_valid_q;
    logic          halted_q;
    logic          fault_q;

    logic [AW-1:0] pc_next;
    logic [WW-1:0] wait_inc;

    // Next-PC candidate; select 3 reloads the current PC for a refetch
    always_comb begin
        pc_next = pc_q;
        case (bus.pcsel)
            2'd0:    pc_next = bus.pcin;
            2'd1:    pc_next = bus.pcbranch;
            2'd2:    pc_next = bus.pcjump;
            default: pc_next = pc_q;
        endcase
    end

    assign wait_inc = wait_q + WW'(1);

    // Next-state, PC, wait-counter and retire-counter logic
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                wait_d  = '0;
            end
            FETCH: begin
                if (bus.mem_ready) begin
                    state_d = EXEC;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_inc;
                    // This cycle is the WAIT_MAX-th without data: give up
                    if (wait_inc == WAIT_MAX) begin
                        state_d = FAULT;
                    end
                end
            end
            EXEC: begin
                if (bus.pc_en) begin
                    pc_d    = pc_next & 16'hFFFE;
                    cnt_d   = cnt_q + AW'(1);
                    state_d = bus.halt ? HALT : FETCH;
                end
            end
            HALT: begin
                if (bus.resume) begin
                    state_d = FETCH;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status outputs registered from the next state so they track state_q exactly
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_req_q   <= 1'b0;
            ins_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            mem_req_q   <= (state_d == FETCH);
            ins_valid_q <= (state_d == EXEC);
            halted_q    <= (state_d == HALT);
            fault_q     <= (state_d == FAULT);
        end
    end

    assign bus.pcout     = pc_q;
    assign bus.ins_count = cnt_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.ins_valid = ins_valid_q;
    assign bus.halted    = halted_q;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential/branch/jump/hold selects,
// memory wait and timeout, halt/resume and asynchronous reset mid-fetch.
module tb_fetch_unit;
    logic clock;
    logic reset_n;
    int   n_assert;
    int   n_fail;

    fetch_if bus ();

    fetch_unit #(
        .RESET_PC (16'h0000),
        .WAIT_MAX (4'd15)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // One-cycle fetch with data ready, leaves the DUT in EXEC
    task automatic fetch_ok();
        bus.mem_ready = 1'b1;
        cyc();
        bus.mem_ready = 1'b0;
    endtask

    // Retire the instruction in EXEC with the given select
    task automatic retire(input logic [1:0] sel);
        bus.pcsel = sel;
        bus.pc_en = 1'b1;
        cyc();
        bus.pc_en = 1'b0;
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        bus.pcin      = 16'h0000;
        bus.pcbranch  = 16'h0000;
        bus.pcjump    = 16'h0000;
        bus.pcsel     = 2'd0;
        bus.pc_en     = 1'b0;
        bus.halt      = 1'b0;
        bus.resume    = 1'b0;
        bus.mem_ready = 1'b0;

        #12;
        chk("rst_pcout", bus.pcout, 16'h0000);
        chk("rst_count", bus.ins_count, 16'h0000);
        chk("rst_mem_req", 16'(bus.mem_req), 16'h0);
        chk("rst_ins_valid", 16'(bus.ins_valid), 16'h0);
        chk("rst_halted", 16'(bus.halted), 16'h0);
        chk("rst_fault", 16'(bus.fault), 16'h0);

        @(negedge clock);
        reset_n = 1'b1;

        // First fetch
        cyc();
        chk("f1_mem_req", 16'(bus.mem_req), 16'h1);
        chk("f1_ins_valid", 16'(bus.ins_valid), 16'h0);
        chk("f1_pcout", bus.pcout, 16'h0000);
        fetch_ok();
        chk("e1_mem_req", 16'(bus.mem_req), 16'h0);
        chk("e1_ins_valid", 16'(bus.ins_valid), 16'h1);

        bus.pcin = 16'h0002;
        retire(2'd0);
        chk("seq_pcout", bus.pcout, 16'h0002);
        chk("seq_count", bus.ins_count, 16'h0001);
        chk("seq_mem_req", 16'(bus.mem_req), 16'h1);

        // EXEC holds without pc_en, halt ignored
        fetch_ok();
        bus.halt = 1'b1;
        cyc();
        bus.halt = 1'b0;
        chk("hold_ins_valid", 16'(bus.ins_valid), 16'h1);
        chk("hold_halted", 16'(bus.halted), 16'h0);
        chk("hold_pcout", bus.pcout, 16'h0002);

        // Branch with odd target, then jump
        bus.pcbranch = 16'h0123;
        retire(2'd1);
        chk("br_pcout", bus.pcout, 16'h0122);
        chk("br_count", bus.ins_count, 16'h0002);
        fetch_ok();
        bus.pcjump = 16'h4A00;
        retire(2'd2);
        chk("jmp_pcout", bus.pcout, 16'h4A00);
        chk("jmp_count", bus.ins_count, 16'h0003);

        // Five wait cycles, then data
        repeat (5) cyc();
        chk("wait_mem_req", 16'(bus.mem_req), 16'h1);
        chk("wait_fault", 16'(bus.fault), 16'h0);
        fetch_ok();
        chk("wait_ins_valid", 16'(bus.ins_valid), 16'h1);
        chk("wait_pcout", bus.pcout, 16'h4A00);
        chk("wait_fault2", 16'(bus.fault), 16'h0);

        // Halt on retire, ignore pc_en, then resume
        bus.pcin = 16'h0010;
        bus.halt = 1'b1;
        retire(2'd0);
        bus.halt = 1'b0;
        chk("halt_halted", 16'(bus.halted), 16'h1);
        chk("halt_pcout", bus.pcout, 16'h0010);
        chk("halt_mem_req", 16'(bus.mem_req), 16'h0);
        chk("halt_count", bus.ins_count, 16'h0004);
        bus.pcjump = 16'h7777;
        retire(2'd2);
        chk("halt_ign_pcout", bus.pcout, 16'h0010);
        chk("halt_ign_count", bus.ins_count, 16'h0004);
        chk("halt_ign_halted", 16'(bus.halted), 16'h1);
        bus.resume = 1'b1;
        cyc();
        bus.resume = 1'b0;
        chk("res_mem_req", 16'(bus.mem_req), 16'h1);
        chk("res_halted", 16'(bus.halted), 16'h0);
        chk("res_pcout", bus.pcout, 16'h0010);

        // Address wrap supplied by datapath, then hold/refetch
        fetch_ok();
        bus.pcjump = 16'hFFFE;
        retire(2'd2);
        chk("ffe_pcout", bus.pcout, 16'hFFFE);
        fetch_ok();
        bus.pcin = 16'h0000;
        retire(2'd0);
        chk("wrap_pcout", bus.pcout, 16'h0000);
        chk("wrap_count", bus.ins_count, 16'h0006);
        fetch_ok();
        bus.pcin = 16'h1234;
        retire(2'd3);
        chk("sel3_pcout", bus.pcout, 16'h0000);
        chk("sel3_count", bus.ins_count, 16'h0007);
        chk("sel3_mem_req", 16'(bus.mem_req), 16'h1);

        // Timeout: FAULT after the 15th wait cycle, sticky
        repeat (14) cyc();
        chk("to14_mem_req", 16'(bus.mem_req), 16'h1);
        chk("to14_fault", 16'(bus.fault), 16'h0);
        cyc();
        chk("to15_fault", 16'(bus.fault), 16'h1);
        chk("to15_mem_req", 16'(bus.mem_req), 16'h0);
        chk("to15_pcout", bus.pcout, 16'h0000);
        bus.mem_ready = 1'b1;
        bus.resume    = 1'b1;
        bus.pc_en     = 1'b1;
        repeat (3) cyc();
        bus.mem_ready = 1'b0;
        bus.resume    = 1'b0;
        bus.pc_en     = 1'b0;
        chk("sticky_fault", 16'(bus.fault), 16'h1);
        chk("sticky_ins_valid", 16'(bus.ins_valid), 16'h0);

        reset_n = 1'b0;
        #2;
        chk("clr_fault", 16'(bus.fault), 16'h0);
        chk("clr_count", bus.ins_count, 16'h0000);
        @(negedge clock);
        reset_n = 1'b1;

        // Data arriving on the limit cycle beats the timeout
        cyc();
        repeat (14) cyc();
        fetch_ok();
        chk("prio_ins_valid", 16'(bus.ins_valid), 16'h1);
        chk("prio_fault", 16'(bus.fault), 16'h0);

        // Asynchronous reset mid-fetch
        bus.pcin = 16'h0A0A;
        retire(2'd0);
        chk("mid_pcout", bus.pcout, 16'h0A0A);
        chk("mid_mem_req", 16'(bus.mem_req), 16'h1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_mem_req", 16'(bus.mem_req), 16'h0);
        chk("async_pcout", bus.pcout, 16'h0000);
        chk("async_count", bus.ins_count, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
